systolic_skew_feeder: RTL
=========================

Name: systolic_skew_feeder

Overview:
- Sits directly upstream of the N x N pe_int8 grid and drives its west and north edges.
- Accepts one K-beat per handshake: N int8 A-column values for the west edge and N int8 B-row values for the north edge.
- Applies the diagonal skew so lane i enters the array i cycles late, and issues the grid-wide accum_reset at tile start.
- After the last beat, flushes zeros until PE(N-1,N-1) has accumulated its final term, then pulses tile_done.

Parameters:
- ARRAY_N, 4, array dimension and number of lanes per edge.
- DATA_WIDTH, 8, signed element width; must match pe_int8.
- MAX_K, 256, maximum beats per tile; sizes the beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  feeder can accept a beat.
- in_last  in  1  final beat of the tile; qualified by in_valid&&in_ready.
- in_west_vec  in  ARRAY_N*DATA_WIDTH  lane i = bits [i*DW +: DW], signed A[i][k].
- in_north_vec  in  ARRAY_N*DATA_WIDTH  lane j = B[k][j], same packing.
- west_edge  out  ARRAY_N*DATA_WIDTH  to inp_west of PE(i,0).
- north_edge  out  ARRAY_N*DATA_WIDTH  to inp_north of PE(0,j).
- accum_reset  out  1  broadcast to every PE.
- busy  out  1  high in any state except IDLE.
- tile_done  out  1  one-cycle pulse; PE results are final and held.
- beat_count  out  $clog2(MAX_K+1)  beats accepted in the current tile.
- k_overflow  out  1  sticky; set when a beat is accepted while beat_count==MAX_K.

Behaviour:
- Reset (synchronous):
  - State IDLE.
  - All skew registers cleared to 0; edges, accum_reset, in_ready, busy, tile_done, k_overflow all 0; beat_count 0.
  - Reset mid-tile abandons the tile. No tile_done is issued.
- IDLE:
  - in_ready=0.
  - in_valid=1 moves to CLEAR. The beat is not consumed.
- CLEAR (1 cycle):
  - accum_reset=1, edge inputs zero, beat_count<=0, k_overflow<=0.
  - Always moves to FEED.
- FEED:
  - in_ready=1.
  - On handshake, lane vectors enter the skew lines and beat_count increments, saturating at MAX_K.
  - A cycle with no handshake injects 0 into every lane. The bubble hits A and B equally, so alignment is preserved and the MAC adds 0.
  - Handshake with in_last: load flush_cnt=2*ARRAY_N-1 and go to FLUSH.
- FLUSH:
  - in_ready=0; zeros are injected.
  - flush_cnt decrements each cycle. At flush_cnt==1 the state moves to DONE.
- DONE (1 cycle):
  - tile_done=1; returns to IDLE.
  - in_valid is ignored until IDLE.
- Skew and latency:
  - Lane i of each edge is a registered delay line of depth i+1.
  - A beat accepted at edge T appears on west_edge/north_edge lane i after edge T+i.
  - Given the one-register hop per PE, PE(i,j) accumulates that beat at edge T+i+j+1.
  - The last term of PE(N-1,N-1) lands at edge T+2N-1, which is the same edge DONE is entered.
- Edge outputs are the delay-line registers only; no combinational path from inputs.
- accum_reset is registered, asserted exactly during CLEAR, and never asserted in FEED, FLUSH or DONE.
- Results stay valid in the PEs after tile_done because zeros keep flowing in IDLE. They are cleared only at the next CLEAR.
- A tile of a single beat with in_last set is legal. A tile with 0 beats is impossible.

Decomposition:
- Package gemma_acc_pkg holds:
  - ARRAY_N, DATA_WIDTH, ACCUM_WIDTH defaults;
  - the state encoding (IDLE, CLEAR, FEED, FLUSH, DONE);
  - the FLUSH_CYCLES = 2*ARRAY_N-1 constant function.
- One sub-module, skew_delay_line (params DEPTH, DATA_WIDTH, sync-reset shift register), instantiated 2*ARRAY_N times through a generate loop with DEPTH=i+1.

Test Plan:
- Reset then idle:
  - Stimulus: rst for 2 cycles, in_valid=0 for 20 cycles.
  - Required: all outputs 0, busy=0, accum_reset never asserted.
- Skew timing (ARRAY_N=4):
  - Stimulus: one beat, west=[1,2,3,4], north=[5,6,7,8], in_last=1, accepted at edge T.
  - Required: west lane i=i+1 and north lane j=j+5 appear after edge T+i, each for exactly one cycle.
  - Required: FLUSH lasts 7 cycles; tile_done after edge T+7; beat_count=1.
- Full tile with 4x4 grid attached:
  - Stimulus: K=4 identity A times B with B[k][j]=k+j, contiguous beats.
  - Required: after tile_done, result(i,j)=i+j; exactly one accum_reset pulse, preceding the first beat.
- Bubbles:
  - Stimulus: same tile as above with in_valid low for 3 cycles between beats 1 and 2.
  - Required: identical results; tile_done delayed by exactly 3 cycles.
- Back-to-back tiles:
  - Stimulus: a second tile of all -128 times -128 with K=2, in_valid held high through DONE.
  - Required: CLEAR precedes it; result(i,j)=32768 in every PE; in_ready=0 during FLUSH/DONE/IDLE/CLEAR.
- Reset mid-FEED and overflow:
  - Stimulus: rst asserted after 2 beats.
  - Required: IDLE next cycle, no tile_done.
  - Stimulus: with MAX_K=4, send 5 beats.
  - Required: k_overflow=1 and beat_count=4.

Source files
------------

// File: rtl/gemma_acc_pkg.sv
// Purpose : shared constants for the int8 systolic accelerator (array size, widths, feeder FSM encoding).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package gemma_acc_pkg;

  localparam int DEFAULT_ARRAY_N     = 4;
  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_ACCUM_WIDTH = 32;

  typedef logic [2:0] feed_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Cycles of zero injection after the last beat before PE(N-1,N-1) holds its final sum.
  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Purpose : fixed-depth shift register delaying one edge lane.
// Latency : DEPTH cycles from din to dout.
// Backpressure: none; shifts every cycle.
// Ports: clk, rst (sync, active-high), din (lane input), dout (oldest stage).
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Purpose : feeds the west/north edges of an N x N pe_int8 grid with diagonal skew, clears and flushes per tile.
// Latency : beat accepted at edge T reaches edge lane i after edge T+i; tile_done after edge T_last+2N-1.
// Backpressure: in_ready high only in FEED; IDLE/CLEAR/FLUSH/DONE hold off the producer.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_last/in_west_vec/in_north_vec beat input;
//        west_edge/north_edge/accum_reset to the grid; busy, tile_done, beat_count, k_overflow status.
module systolic_skew_feeder
  import gemma_acc_pkg::*;
#(
  parameter int ARRAY_N    = DEFAULT_ARRAY_N,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_K      = 256,
  localparam int CNT_W     = $clog2(MAX_K + 1),
  localparam int VEC_W     = ARRAY_N * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [VEC_W-1:0] in_west_vec,
  input  logic [VEC_W-1:0] in_north_vec,
  output logic [VEC_W-1:0] west_edge,
  output logic [VEC_W-1:0] north_edge,
  output logic             accum_reset,
  output logic             busy,
  output logic             tile_done,
  output logic [CNT_W-1:0] beat_count,
  output logic             k_overflow
);

  localparam int FL_W = $clog2(2 * ARRAY_N);
  localparam logic [FL_W-1:0]  FLUSH_LEN = FL_W'(flush_cycles(ARRAY_N));
  localparam logic [CNT_W-1:0] MAX_K_C   = CNT_W'(MAX_K);

  feed_state_t     state;
  logic [FL_W-1:0] flush_cnt;
  logic            hs;

  assign hs = in_valid && (state == ST_FEED);

  // All control outputs are decodes of the state register, so none has a path from the inputs.
  assign in_ready    = (state == ST_FEED);
  assign busy        = (state != ST_IDLE);
  assign tile_done   = (state == ST_DONE);
  assign accum_reset = (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      beat_count <= '0;
      k_overflow <= 1'b0;
    end else begin
      case (state)
        // The beat that wakes us is left on the bus and taken in FEED.
        ST_IDLE: if (in_valid) state <= ST_CLEAR;
        ST_CLEAR: begin
          beat_count <= '0;
          k_overflow <= 1'b0;
          state      <= ST_FEED;
        end
        ST_FEED: begin
          if (hs) begin
            if (beat_count == MAX_K_C) k_overflow <= 1'b1;
            else                       beat_count <= beat_count + 1'b1;
            if (in_last) begin
              flush_cnt <= FLUSH_LEN;
              state     <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt - 1'b1;
          if (flush_cnt == FL_W'(1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Non-handshake cycles push zeros into both edges alike, keeping A/B alignment and adding 0 in the MACs.
  for (genvar g = 0; g < ARRAY_N; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] west_din;
    logic [DATA_WIDTH-1:0] north_din;

    assign west_din  = hs ? in_west_vec[g*DATA_WIDTH +: DATA_WIDTH]  : '0;
    assign north_din = hs ? in_north_vec[g*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_delay_line #(.DEPTH(g + 1), .DATA_WIDTH(DATA_WIDTH)) u_west (
      .clk  (clk),
      .rst  (rst),
      .din  (west_din),
      .dout (west_edge[g*DATA_WIDTH +: DATA_WIDTH])
    );

    skew_delay_line #(.DEPTH(g + 1), .DATA_WIDTH(DATA_WIDTH)) u_north (
      .clk  (clk),
      .rst  (rst),
      .din  (north_din),
      .dout (north_edge[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
